// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the FIFO read scheduler: FSM encoding, a
// constant-usable clog2, and the round-robin pick helper.
package fifo_sched_pkg;

    // FSM encoding kept as plain constants so legacy netlists and
    // waveforms keep the same state values.
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    // Upper bound on channel count handled by rr_pick.
    localparam int unsigned MAX_CH = 16;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // First set bit of req at or after ptr, wrapping from n-1 back to 0.
    // Only the low n bits of req are considered; returns 0 if none set.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_CH-1:0] req,
        input logic [3:0]        ptr,
        input int unsigned       n
    );
        logic [3:0] pick;
        logic       found;
        logic [4:0] s;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            s = {1'b0, ptr} + 5'(i);
            if (s >= 5'(n)) begin
                s = s - 5'(n);
            end
            if ((i < n) && !found && req[s[3:0]]) begin
                pick  = s[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_sched_obuf.sv
// Two-entry output buffer. The head entry is a register that drives the
// output directly, so there is no combinational path from pop to data.
module fifo_sched_obuf
    import fifo_sched_pkg::*;
#(
    parameter int unsigned DW  = 8,
    parameter int unsigned CHW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DW+CHW-1:0] pdata,
    input  logic              pop,
    output logic [1:0]        occ,
    output logic              ovalid,
    output logic [DW+CHW-1:0] odata
);

    localparam int unsigned W = DW + CHW;

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_occ;
    logic         w_pop;

    // A pop request is only honoured when the head actually holds a word.
    assign w_pop = pop & (r_occ != 2'd0);

    // Head/tail shift register with occupancy count; push+pop at occ=1
    // replaces the head in place so occupancy stays at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            case ({push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= pdata;
                        r_occ  <= 2'd1;
                    end else if (r_occ == 2'd1) begin
                        r_tail <= pdata;
                        r_occ  <= 2'd2;
                    end
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head <= pdata;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= pdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign occ    = r_occ;
    assign ovalid = (r_occ != 2'd0);
    assign odata  = r_head;

endmodule

// File: rtl/fifo_rd_sched.sv
// Round-robin read scheduler: shares one downstream consumer among NCH
// FIFO read ports, granting bursts of up to BURST reads per channel and
// draining captured words through a tagged 2-entry output buffer.
module fifo_rd_sched
    import fifo_sched_pkg::*;
#(
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned DW    = 8,
    parameter  int unsigned BURST = 4,
    localparam int unsigned CHW   = clog2(NCH)
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH-1:0]    rempty,
    output logic [NCH-1:0]    rden,
    input  logic [NCH*DW-1:0] rdata,
    output logic              ovalid,
    input  logic              ordy,
    output logic [DW-1:0]     odata,
    output logic [CHW-1:0]    och,
    output logic              busy
);

    localparam int unsigned CW = clog2(BURST + 1);

    logic              r_state;
    logic [CHW-1:0]    r_ptr;
    logic [CHW-1:0]    r_gnt;
    logic [CW-1:0]     r_cnt;
    logic              r_infl;
    logic [CHW-1:0]    r_rdch;

    logic [NCH-1:0]    w_elig;
    logic [CHW-1:0]    w_pick;
    logic [CHW-1:0]    w_gnt_inc;
    logic [1:0]        w_occ;
    logic [2:0]        w_load;
    logic              w_pop;
    logic              w_space;
    logic              w_issue;
    logic [CHW-1:0]    w_issue_ch;
    logic              w_state_nxt;
    logic [CHW-1:0]    w_gnt_nxt;
    logic [CHW-1:0]    w_ptr_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [DW-1:0]     w_rd_word;
    logic [DW+CHW-1:0] w_head;

    assign w_elig = ch_en & ~rempty;
    assign w_pick = CHW'(rr_pick(16'(w_elig), 4'(r_ptr), NCH));
    assign w_pop  = ovalid & ordy;

    // Buffer slots already committed: stored words plus the word in flight.
    // A new read fits if fewer than 2 are committed, or exactly 2 with a
    // pop freeing one on this edge.
    assign w_load  = 3'(w_occ) + 3'(r_infl);
    assign w_space = (w_load < 3'd2) | ((w_load == 3'd2) & w_pop);

    assign w_gnt_inc = (r_gnt == CHW'(NCH - 1)) ? '0 : r_gnt + CHW'(1);

    // Arbitration FSM: pick a channel in IDLE, then keep reading it until
    // the burst limit is hit or it stops being eligible. A stall for lack
    // of buffer space holds the grant without advancing the count.
    always_comb begin
        w_issue     = 1'b0;
        w_issue_ch  = r_gnt;
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        if (r_state == ST_IDLE) begin
            if (|w_elig) begin
                w_issue     = w_space;
                w_issue_ch  = w_pick;
                w_state_nxt = ST_BURST;
                w_gnt_nxt   = w_pick;
                w_cnt_nxt   = CW'(w_space);
            end
        end else begin
            w_issue   = w_elig[r_gnt] & w_space & (r_cnt < CW'(BURST));
            w_cnt_nxt = r_cnt + CW'(w_issue);
            if (!w_elig[r_gnt] || (w_cnt_nxt == CW'(BURST))) begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = w_gnt_inc;
                w_cnt_nxt   = '0;
            end
        end
    end

    // One-hot read strobe, forced low while reset is asserted.
    always_comb begin
        rden = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_issue && !rrst && (w_issue_ch == CHW'(i))) begin
                rden[i] = 1'b1;
            end
        end
    end

    // Select the read data of the channel read on the previous cycle.
    always_comb begin
        w_rd_word = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (r_rdch == CHW'(i)) begin
                w_rd_word = rdata[i*DW +: DW];
            end
        end
    end

    // FSM state, grant, burst count, round-robin pointer and the
    // one-deep read-in-flight tracker.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_infl  <= 1'b0;
            r_rdch  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_infl  <= w_issue;
            if (w_issue) begin
                r_rdch <= w_issue_ch;
            end
        end
    end

    fifo_sched_obuf #(
        .DW  (DW),
        .CHW (CHW)
    ) u_obuf (
        .clk    (rclk),
        .rst    (rrst),
        .push   (r_infl),
        .pdata  ({r_rdch, w_rd_word}),
        .pop    (w_pop),
        .occ    (w_occ),
        .ovalid (ovalid),
        .odata  (w_head)
    );

    assign och   = w_head[DW +: CHW];
    assign odata = w_head[DW-1:0];
    assign busy  = (r_state == ST_BURST) | r_infl | (w_occ != 2'd0);

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched: models four FIFOs whose words encode
// {channel, read index}, collects every output transfer and checks channel
// order and data against hand-derived sequences.
module tb_fifo_rd_sched;

    localparam int NCH   = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             rrst;
    logic [NCH-1:0]   ch_en;
    logic [NCH-1:0]   rempty;
    logic [NCH-1:0]   rden;
    logic [NCH*DW-1:0] rdata;
    logic             ovalid;
    logic             ordy;
    logic [DW-1:0]    odata;
    logic [1:0]       och;
    logic             busy;

    always #5 clk = ~clk;

    fifo_rd_sched #(
        .NCH   (NCH),
        .DW    (DW),
        .BURST (BURST)
    ) dut (
        .rclk   (clk),
        .rrst   (rrst),
        .ch_en  (ch_en),
        .rempty (rempty),
        .rden   (rden),
        .rdata  (rdata),
        .ovalid (ovalid),
        .ordy   (ordy),
        .odata  (odata),
        .och    (och),
        .busy   (busy)
    );

    // FIFO model: wptr moved by the stimulus, rptr by reads.
    int unsigned wptr [NCH] = '{default: 0};
    int unsigned rptr [NCH] = '{default: 0};
    logic [7:0]  rd_r [NCH] = '{default: 8'h00};
    int          underflow = 0;
    int          bad_oh = 0;
    int          cyc = 0;

    int          ncmp = 0;
    int          nfail = 0;

    int          q_ch  [$];
    logic [7:0]  q_dat [$];
    int          q_cyc [$];
    int          exp_q [$];
    int          nxt [NCH] = '{default: 0};
    int          base = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NCH; i++) begin
            if (rden[i]) begin
                if (wptr[i] == rptr[i]) underflow <= underflow + 1;
                rd_r[i] <= {2'(i), 6'(rptr[i])};
                rptr[i] <= rptr[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) rempty[i] = (wptr[i] == rptr[i]);
    end

    assign rdata = {rd_r[3], rd_r[2], rd_r[1], rd_r[0]};

    always @(negedge clk) begin
        if (!rrst && ovalid && ordy) begin
            q_ch.push_back(int'(och));
            q_dat.push_back(odata);
            q_cyc.push_back(cyc);
        end
        if (!$onehot0(rden)) bad_oh <= bad_oh + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add_run(input int c, input int n);
        repeat (n) exp_q.push_back(c);
    endtask

    task automatic load(input int c, input int n);
        wptr[c] = rptr[c] + n;
    endtask

    // Wait for the expected words, let the DUT go idle, then compare.
    task automatic verify(input string tag);
        int n;
        int k;
        int c;
        n = exp_q.size();
        k = 0;
        while ((q_ch.size() < base + n) && (k < 400)) begin
            step(1);
            k++;
        end
        k = 0;
        while (busy && (k < 100)) begin
            step(1);
            k++;
        end
        chk($sformatf("%s idle", tag), busy, 0);
        step(2);
        chk($sformatf("%s count", tag), q_ch.size() - base, n);
        for (int i = 0; (i < n) && (base + i < q_ch.size()); i++) begin
            c = exp_q[i];
            chk($sformatf("%s och[%0d]", tag, i), q_ch[base + i], c);
            chk($sformatf("%s data[%0d]", tag, i), q_dat[base + i], {2'(c), 6'(nxt[c])});
            nxt[c]++;
        end
        base = q_ch.size();
        exp_q.delete();
    endtask

    task automatic wait_reads(input string tag, input int c, input int unsigned r0, input int n);
        int k;
        k = 0;
        while ((rptr[c] - r0 < n) && (k < 50)) begin
            step(1);
            k++;
        end
        chk(tag, rptr[c] - r0, n);
    endtask

    initial begin
        int b0;
        int unsigned r0;
        int unsigned rs [NCH];
        logic [7:0] held;
        int k;

        // Reset with every FIFO non-empty
        rrst  = 1'b1;
        ordy  = 1'b1;
        ch_en = 4'hF;
        for (int c = 0; c < NCH; c++) load(c, 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst rden %0d", i), rden, 0);
            chk($sformatf("rst ovalid %0d", i), ovalid, 0);
            chk($sformatf("rst busy %0d", i), busy, 0);
        end
        step(1);
        rrst  = 1'b0;
        ch_en = 4'h0;
        @(negedge clk);
        chk("post rst rden", rden, 0);
        chk("post rst ovalid", ovalid, 0);
        chk("post rst busy", busy, 0);
        chk("post rst odata", odata, 0);
        chk("post rst och", och, 0);
        step(1);

        // Fairness: all channels 8 words, ordy=1
        ch_en = 4'hF;
        b0 = base;
        for (int r = 0; r < 2; r++) for (int c = 0; c < NCH; c++) add_run(c, 4);
        verify("fair");
        if (base - b0 == 32) begin
            chk("fair span", (q_cyc[b0 + 31] - q_cyc[b0]) <= 38, 1);
        end else begin
            chk("fair words", base - b0, 32);
        end

        // Short channel: ch1 holds only 2 words
        load(0, 8); load(1, 2); load(2, 8); load(3, 8);
        add_run(0, 4); add_run(1, 2); add_run(2, 4); add_run(3, 4);
        add_run(0, 4); add_run(2, 4); add_run(3, 4);
        verify("short");

        // Backpressure mid-burst on ch2
        r0 = rptr[2];
        load(2, 8);
        k = 0;
        while ((q_ch.size() < base + 2) && (k < 50)) begin
            step(1);
            k++;
        end
        ordy = 1'b0;
        step(3);
        held = odata;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("bp rden %0d", i), rden, 0);
            chk($sformatf("bp ovalid %0d", i), ovalid, 1);
            chk($sformatf("bp hold %0d", i), odata, held);
        end
        chk("bp buffered", (rptr[2] - r0) - (q_ch.size() - base), 2);
        step(1);
        ordy = 1'b1;
        add_run(2, 8);
        verify("bp");

        // Enable mask 1010, then drop ch3 mid-burst
        for (int c = 0; c < NCH; c++) begin
            rs[c] = rptr[c];
            load(c, 8);
        end
        ch_en = 4'b1010;
        wait_reads("skip ch3 start", 3, rs[3], 2);
        ch_en = 4'b0010;
        add_run(3, 2); add_run(1, 8);
        verify("skip");
        chk("skip ch3 reads", rptr[3] - rs[3], 2);
        chk("skip ch0 reads", rptr[0] - rs[0], 0);
        chk("skip ch2 reads", rptr[2] - rs[2], 0);
        ch_en = 4'h0;
        step(2);
        for (int c = 0; c < NCH; c++) begin
            wptr[c] = rptr[c];
            nxt[c]  = int'(rptr[c]);
        end

        // Reset pulse with a word buffered and one in flight
        ordy = 1'b0;
        r0 = rptr[2];
        for (int c = 0; c < NCH; c++) load(c, 8);
        ch_en = 4'hF;
        wait_reads("mrst reads", 2, r0, 2);
        chk("mrst ovalid before", ovalid, 1);
        rrst = 1'b1;
        step(1);
        rrst = 1'b0;
        @(negedge clk);
        chk("mrst ovalid", ovalid, 0);
        chk("mrst busy", busy, 0);
        chk("mrst restart ch0", rden, 4'b0001);
        nxt[2] = nxt[2] + 2;
        ordy = 1'b1;
        for (int c = 0; c < NCH; c++) add_run(c, 4);
        add_run(0, 4); add_run(1, 4); add_run(2, 2); add_run(3, 4);
        verify("mrst");

        chk("underflow", underflow, 0);
        chk("rden onehot", bad_oh, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
